// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
// Downstream stage of the 3-bit adder. Takes {carry,sum} as a 4-bit sample
// (0..15) and adds up COUNT accepted samples into a block total. The total is
// then offered to the next stage on a valid/ready handshake.
// Optional build macro: ADDER_ACC_SATURATE_EN. When it is defined, a block
// total that overflows clamps to all-ones. When it is not defined, the total
// wraps modulo 2^ACC_WIDTH.
// ACC_WIDTH must be at least 4 so that a single sample always fits.
module adder_sum_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sum,
  input  logic                 carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 overflow,
  output logic [CNT_W-1:0]     sample_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [ACC_WIDTH-1:0] total_reg, total_next;
  logic                 overflow_reg, overflow_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  logic                 accept;
  logic [ACC_WIDTH:0]   v_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 add_carry;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 last_sample;

  // Datapath helpers. The sample is only consumed on accept, so anything
  // present on sum/carry while in_valid is low cannot reach the registers.
  assign accept      = in_valid & in_ready;
  assign v_ext       = (ACC_WIDTH+1)'({carry, sum});
  assign sum_ext     = {1'b0, total_reg} + v_ext;
  assign add_carry   = sum_ext[ACC_WIDTH];
  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign last_sample = (cnt_inc == CNT_W'(COUNT));

  // State register and block datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      total_reg    <= '0;
      overflow_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      total_reg    <= total_next;
      overflow_reg <= overflow_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Next-state logic: fill the block, then hold it until downstream takes it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (COUNT == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last_sample) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so they are never high together
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on the first sample, add on later ones, clear on consume
  always_comb begin
    total_next    = total_reg;
    overflow_next = overflow_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          total_next    = v_ext[ACC_WIDTH-1:0];
          overflow_next = 1'b0;
          cnt_next      = CNT_W'(1);
        end
      end
      ACCUM: begin
        if (accept) begin
          overflow_next = overflow_reg | add_carry;
          cnt_next      = cnt_inc;
`ifdef ADDER_ACC_SATURATE_EN
          // Once clamped, the total stays at all-ones for the rest of the block.
          total_next    = (overflow_reg | add_carry) ? {ACC_WIDTH{1'b1}}
                                                     : sum_ext[ACC_WIDTH-1:0];
`else
          total_next    = sum_ext[ACC_WIDTH-1:0];
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          total_next    = '0;
          overflow_next = 1'b0;
          cnt_next      = '0;
        end
      end
      default: begin
        total_next    = '0;
        overflow_next = 1'b0;
        cnt_next      = '0;
      end
    endcase
  end

  assign total      = total_reg;
  assign overflow   = overflow_reg;
  assign sample_cnt = cnt_reg;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Testbench for adder_sum_accumulator.
// Three instances share one input stream: (ACC_WIDTH=8, COUNT=4),
// (ACC_WIDTH=4, COUNT=4) and (ACC_WIDTH=8, COUNT=1). A block-level reference
// model tracks all three and is compared on every cycle. Directed sequences
// add literal expectations that pin the model itself.
module tb_adder_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       carry = 1'b0;
  logic [2:0] sum = 3'd0;

  logic       ir [3];
  logic       ov [3];
  logic       of [3];
  logic [7:0] t0, t2;
  logic [3:0] t1;
  logic [7:0] c0, c1, c2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.ACC_WIDTH(8), .COUNT(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .sum(sum), .carry(carry), .out_valid(ov[0]), .out_ready(out_ready),
    .total(t0), .overflow(of[0]), .sample_cnt(c0)
  );
  adder_sum_accumulator #(.ACC_WIDTH(4), .COUNT(4), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .sum(sum), .carry(carry), .out_valid(ov[1]), .out_ready(out_ready),
    .total(t1), .overflow(of[1]), .sample_cnt(c1)
  );
  adder_sum_accumulator #(.ACC_WIDTH(8), .COUNT(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .sum(sum), .carry(carry), .out_valid(ov[2]), .out_ready(out_ready),
    .total(t2), .overflow(of[2]), .sample_cnt(c2)
  );

  // ---------------- reference model (block level) ----------------
  int W [3] = '{8, 4, 8};
  int C [3] = '{4, 4, 1};
  int m_total [3];
  int m_cnt   [3];
  bit m_hold  [3];
  bit m_ovf   [3];
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int v, s, lim;
      v   = int'({carry, sum});
      lim = 1 << W[k];
      if (rst) begin
        m_total[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_total[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
        end
      end else if (in_valid) begin
        if (m_cnt[k] == 0) begin
          m_total[k] = v % lim;
          m_ovf[k]   = 0;
        end else begin
          s = m_total[k] + v;
          if (s >= lim) m_ovf[k] = 1;
`ifdef ADDER_ACC_SATURATE_EN
          m_total[k] = m_ovf[k] ? lim - 1 : s;
`else
          m_total[k] = s % lim;
`endif
        end
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == C[k]) m_hold[k] = 1;
      end
    end
    model_ok = 1'b1;
  end

  function automatic int dut_total(int k);
    case (k)
      0:       return int'(t0);
      1:       return int'(t1);
      default: return int'(t2);
    endcase
  endfunction

  function automatic int dut_cnt(int k);
    case (k)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s u%0d actual=%0d required=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int k = 0; k < 3; k++) begin
          chk("cyc_in_ready",  k, int'(ir[k]), int'(!m_hold[k]));
          chk("cyc_out_valid", k, int'(ov[k]), int'(m_hold[k]));
          chk("cyc_total",     k, dut_total(k), m_total[k]);
          chk("cyc_overflow",  k, int'(of[k]), int'(m_ovf[k]));
          chk("cyc_cnt",       k, dut_cnt(k), m_cnt[k]);
          chk("cyc_excl",      k, int'(ir[k] & ov[k]), 0);
        end
      end
    end
  endtask

  // Drive inputs just after a rising edge. On return, the outputs show the
  // result of the edge that just passed.
  task automatic step(input logic iv, input int val, input logic ordy, input logic r);
    @(posedge clk);
    #1;
    in_valid  = iv;
    {carry, sum} = 4'(val);
    out_ready = ordy;
    rst       = r;
  endtask

  task automatic txn(input string nm);
    $display("txn %-10s u0: valid=%0d total=%0d ovf=%0d cnt=%0d | u1: total=%0d ovf=%0d",
             nm, ov[0], t0, of[0], c0, t1, of[1]);
  endtask

  int blk_exp [4] = '{6, 22, 38, 54};

  initial begin
    fork
      compare_loop();
    join_none

    // reset
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_in_ready", 0, int'(ir[0]), 1);
    chk("rst_total",    0, int'(t0), 0);
    chk("rst_cnt",      0, int'(c0), 0);
    txn("reset");

    // basic block 3+5+15+2 = 25, out_valid for exactly one cycle
    step(1, 3, 1, 0); step(1, 5, 1, 0); step(1, 15, 1, 0); step(1, 2, 1, 0);
    step(0, 0, 1, 0);
    chk("basic_valid", 0, int'(ov[0]), 1);
    chk("basic_total", 0, int'(t0), 25);
    chk("basic_ovf",   0, int'(of[0]), 0);
    chk("basic_cnt",   0, int'(c0), 4);
    txn("basic");
    step(0, 0, 1, 0);
    chk("basic_after_valid", 0, int'(ov[0]), 0);
    chk("basic_after_ready", 0, int'(ir[0]), 1);

    // back-pressure: block held stable while out_ready is low
    step(1, 3, 0, 0); step(1, 5, 0, 0); step(1, 15, 0, 0); step(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("bp_valid", 0, int'(ov[0]), 1);
      chk("bp_total", 0, int'(t0), 25);
      chk("bp_ready", 0, int'(ir[0]), 0);
    end
    txn("backpress");
    step(0, 0, 1, 0);
    chk("bp_still_valid", 0, int'(ov[0]), 1);
    step(0, 0, 0, 0);
    chk("bp_released", 0, int'(ov[0]), 0);
    chk("bp_released_ready", 0, int'(ir[0]), 1);

    // overflow: four samples of 15
    step(1, 15, 1, 0); step(1, 15, 1, 0); step(1, 15, 1, 0); step(1, 15, 1, 0);
    step(0, 0, 1, 0);
    chk("ovf_total_w8", 0, int'(t0), 60);
    chk("ovf_flag_w8",  0, int'(of[0]), 0);
`ifdef ADDER_ACC_SATURATE_EN
    chk("ovf_total_w4", 1, int'(t1), 15);
`else
    chk("ovf_total_w4", 1, int'(t1), 12);
`endif
    chk("ovf_flag_w4",  1, int'(of[1]), 1);
    txn("overflow");
    step(0, 0, 1, 0);

    // gapped input 1,0,0,1,0,1,1 with values 1,2,3,4
    step(1, 1, 1, 0); step(0, 7, 1, 0); step(0, 7, 1, 0);
    chk("gap_hold_total", 0, int'(t0), 1);
    chk("gap_hold_cnt",   0, int'(c0), 1);
    step(1, 2, 1, 0); step(0, 5, 1, 0); step(1, 3, 1, 0); step(1, 4, 1, 0);
    step(0, 0, 1, 0);
    chk("gap_total", 0, int'(t0), 10);
    chk("gap_valid", 0, int'(ov[0]), 1);
    txn("gapped");
    step(0, 0, 1, 0);

    // reset mid-block with a sample presented on the reset cycle
    step(1, 9, 1, 0); step(1, 6, 1, 0); step(1, 5, 1, 1); step(0, 0, 1, 0);
    chk("mid_rst_total", 0, int'(t0), 0);
    chk("mid_rst_cnt",   0, int'(c0), 0);
    chk("mid_rst_ovf",   0, int'(of[0]), 0);
    chk("mid_rst_ready", 0, int'(ir[0]), 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    step(0, 0, 1, 0);
    chk("mid_rst_block", 0, int'(t0), 4);
    txn("mid_reset");
    step(0, 0, 1, 0);

    // all 16 {carry,sum} values as four blocks of four
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) step(1, 4 * b + j, 1, 0);
      step(0, 0, 1, 0);
      chk("exh_total", 0, int'(t0), blk_exp[b]);
      txn("exhaustive");
      step(0, 0, 1, 0);
    end

    // randomized traffic, checked every cycle by the compare loop
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    txn("random");
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
